// File: rtl/instr_fetch_buffer_if.sv
// Fetch-buffer bus: imem response side plus issue-side pair presentation.
// No logic inside; signal bundle only.
// master drives imem/stall/flush, slave is the buffer itself.
interface instr_fetch_buffer_if #(
    parameter int INSTR_W = 16
);
    logic               imem_vld;
    logic [INSTR_W-1:0] imem_instr1;
    logic [INSTR_W-1:0] imem_instr2;
    logic               imem_instr2_vld;
    logic               imem_rdy;
    logic               stall;
    logic               flush;
    logic [INSTR_W-1:0] new_instr1_in;
    logic [INSTR_W-1:0] new_instr2_in;
    logic               ins_new_1_vld;
    logic               ins_new_2_vld;
    logic               fetch_empty;
    logic               fetch_full;

    modport master (
        output imem_vld, imem_instr1, imem_instr2, imem_instr2_vld, stall, flush,
        input  imem_rdy, new_instr1_in, new_instr2_in, ins_new_1_vld, ins_new_2_vld,
               fetch_empty, fetch_full
    );

    modport slave (
        input  imem_vld, imem_instr1, imem_instr2, imem_instr2_vld, stall, flush,
        output imem_rdy, new_instr1_in, new_instr2_in, ins_new_1_vld, ins_new_2_vld,
               fetch_empty, fetch_full
    );
endinterface

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer: ring FIFO of single instructions, 0-2 in and 0-2 out per cycle.
// Latency: imem_vld at edge t -> ins_new_1_vld after edge t+1; flush drops FLUSH_DROP responses.
// Backpressure: imem_rdy only when a full pair fits; stall holds output regs. FETCH_PERF_EN adds perf counters.
module instr_fetch_buffer #(
    parameter int INSTR_W    = 16,
    parameter int DEPTH      = 8,
    parameter int FLUSH_DROP = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_fetch_buffer_if.slave  bus
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]          perf_stall_cnt_o,
    output logic [15:0]          perf_flush_cnt_o
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int DW = (FLUSH_DROP < 1) ? 1 : $clog2(FLUSH_DROP + 1);

    typedef enum logic {RUN, DROP} state_t;

    state_t             state_q;
    logic [DW-1:0]      drop_cnt_q;
    logic [DW-1:0]      drop_cnt_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d, rd_ptr_p1;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d, wr_ptr_p1;
    logic [CW-1:0]      count_q, count_d;
    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [INSTR_W-1:0] instr1_q, instr2_q;
    logic               vld1_q, vld2_q;

    logic               imem_rdy_c;
    logic               accept;
    logic               push;
    logic               load;
    logic [CW-1:0]      push_n;
    logic [CW-1:0]      pop_n;

    // Handshake decode and next-state pointer/count arithmetic
    always_comb begin
        imem_rdy_c = 1'b0;
        if (state_q == RUN) begin
            imem_rdy_c = (count_q <= CW'(DEPTH - 2)) && !bus.flush;
        end else begin
            // wrong-path responses are thrown away, so room is irrelevant
            imem_rdy_c = !bus.flush;
        end
        accept     = bus.imem_vld && imem_rdy_c;
        push       = accept && (state_q == RUN);
        push_n     = '0;
        if (push) begin
            push_n = bus.imem_instr2_vld ? CW'(2) : CW'(1);
        end
        load       = !bus.stall || !vld1_q;
        pop_n      = '0;
        if (load) begin
            pop_n = (count_q >= CW'(2)) ? CW'(2) : count_q;
        end
        rd_ptr_p1  = rd_ptr_q + PW'(1);
        wr_ptr_p1  = wr_ptr_q + PW'(1);
        rd_ptr_d   = rd_ptr_q + PW'(pop_n);
        wr_ptr_d   = wr_ptr_q + PW'(push_n);
        count_d    = count_q + push_n - pop_n;
        drop_cnt_d = drop_cnt_q + DW'(1);
    end

    // Flush-drop FSM: count discarded responses after a misprediction
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            drop_cnt_q <= '0;
        end else if (bus.flush) begin
            state_q    <= (FLUSH_DROP == 0) ? RUN : DROP;
            drop_cnt_q <= '0;
        end else if (state_q == DROP && accept) begin
            drop_cnt_q <= drop_cnt_d;
            if (drop_cnt_d == DW'(FLUSH_DROP)) begin
                state_q <= RUN;
            end
        end
    end

    // Storage array: up to two consecutive slots written per accepted response
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= bus.imem_instr1;
            if (bus.imem_instr2_vld) begin
                mem_q[wr_ptr_p1] <= bus.imem_instr2;
            end
        end
    end

    // Pointers, occupancy and the issue-side output pair
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            vld1_q   <= 1'b0;
            vld2_q   <= 1'b0;
            instr1_q <= '0;
            instr2_q <= '0;
        end else if (bus.flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            vld1_q   <= 1'b0;
            vld2_q   <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (load) begin
                vld1_q   <= (pop_n != '0);
                vld2_q   <= (pop_n == CW'(2));
                instr1_q <= mem_q[rd_ptr_q];
                instr2_q <= mem_q[rd_ptr_p1];
            end
        end
    end

    // The imem_rdy rule makes this unreachable; guards future edits to it
    assert property (@(posedge clk) disable iff (rst) push |-> (count_q <= CW'(DEPTH - 2)));

`ifdef FETCH_PERF_EN
    logic [15:0] perf_stall_q, perf_flush_q;

    // Saturating event counters for stalled-valid and flush cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (bus.stall && vld1_q && perf_stall_q != 16'hFFFF) begin
                perf_stall_q <= perf_stall_q + 16'd1;
            end
            if (bus.flush && perf_flush_q != 16'hFFFF) begin
                perf_flush_q <= perf_flush_q + 16'd1;
            end
        end
    end

    assign perf_stall_cnt_o = perf_stall_q;
    assign perf_flush_cnt_o = perf_flush_q;
`endif

    assign bus.imem_rdy      = imem_rdy_c;
    assign bus.new_instr1_in = instr1_q;
    assign bus.new_instr2_in = instr2_q;
    assign bus.ins_new_1_vld = vld1_q;
    assign bus.ins_new_2_vld = vld2_q;
    assign bus.fetch_empty   = (count_q == '0);
    assign bus.fetch_full    = (count_q == CW'(DEPTH));
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: vector table, directed corner sequences, random vs queue model.
module tb_instr_fetch_buffer;
    localparam int INSTR_W    = 16;
    localparam int DEPTH      = 8;
    localparam int FLUSH_DROP = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_fetch_buffer_if #(.INSTR_W(INSTR_W)) bus ();

`ifdef FETCH_PERF_EN
    logic [15:0] perf_stall_cnt;
    logic [15:0] perf_flush_cnt;
`endif

    instr_fetch_buffer #(.INSTR_W(INSTR_W), .DEPTH(DEPTH), .FLUSH_DROP(FLUSH_DROP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall_cnt_o (perf_stall_cnt),
        .perf_flush_cnt_o (perf_flush_cnt)
`endif
    );

    int vec  = 0;
    int errs = 0;

    // ---------------- reference model: program-order queue ----------------
    logic [15:0] m_fifo[$];
    logic [15:0] sb_q[$];
    logic        m_v1 = 1'b0, m_v2 = 1'b0;
    logic [15:0] m_d1 = '0, m_d2 = '0;
    int          m_drop = 0;
    bit          sb_en = 1'b0;
    int          issued = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chkint(input string nm, input int act, input int exp);
        vec++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic model_rdy();
        return !bus.flush && (m_drop > 0 || m_fifo.size() <= DEPTH - 2);
    endfunction

    task automatic model_edge();
        logic acc;
        int   n;
        acc = bus.imem_vld && model_rdy();
        if (rst) begin
            m_fifo.delete();
            m_v1 = 1'b0; m_v2 = 1'b0; m_d1 = '0; m_d2 = '0;
            m_drop = 0;
        end else if (bus.flush) begin
            m_fifo.delete();
            m_v1 = 1'b0; m_v2 = 1'b0;
            m_drop = FLUSH_DROP;
        end else begin
            if (!bus.stall || !m_v1) begin
                n = (m_fifo.size() >= 2) ? 2 : m_fifo.size();
                m_v1 = (n >= 1);
                m_v2 = (n >= 2);
                if (n >= 1) m_d1 = m_fifo.pop_front();
                if (n >= 2) m_d2 = m_fifo.pop_front();
            end
            if (acc) begin
                if (m_drop > 0) begin
                    m_drop--;
                end else begin
                    m_fifo.push_back(bus.imem_instr1);
                    if (sb_en) sb_q.push_back(bus.imem_instr1);
                    if (bus.imem_instr2_vld) begin
                        m_fifo.push_back(bus.imem_instr2);
                        if (sb_en) sb_q.push_back(bus.imem_instr2);
                    end
                end
            end
        end
    endtask

    task automatic check_model();
        chk1("m_vld1", bus.ins_new_1_vld, m_v1);
        chk1("m_vld2", bus.ins_new_2_vld, m_v2);
        if (m_v1) chk16("m_instr1", bus.new_instr1_in, m_d1);
        if (m_v2) chk16("m_instr2", bus.new_instr2_in, m_d2);
        if (bus.ins_new_2_vld && !bus.ins_new_1_vld) chk1("vld2_without_vld1", 1'b1, 1'b0);
        chk1("m_imem_rdy", bus.imem_rdy, model_rdy());
        chk1("m_empty", bus.fetch_empty, m_fifo.size() == 0);
        chk1("m_full", bus.fetch_full, m_fifo.size() == DEPTH);
    endtask

    // one clock: scoreboard transfer check, edge, model update, compare on falling edge
    task automatic cycle();
        if (sb_en && bus.ins_new_1_vld && !bus.stall) begin
            if (sb_q.size() == 0) begin
                chk1("sb_extra_issue", 1'b1, 1'b0);
            end else begin
                chk16("sb_order1", bus.new_instr1_in, sb_q.pop_front());
                issued++;
            end
            if (bus.ins_new_2_vld) begin
                if (sb_q.size() == 0) begin
                    chk1("sb_extra_issue2", 1'b1, 1'b0);
                end else begin
                    chk16("sb_order2", bus.new_instr2_in, sb_q.pop_front());
                    issued++;
                end
            end
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic drive(input logic r, input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic i2v, input logic st, input logic fl);
        rst                 = r;
        bus.imem_vld        = v;
        bus.imem_instr1     = a;
        bus.imem_instr2     = b;
        bus.imem_instr2_vld = i2v;
        bus.stall           = st;
        bus.flush           = fl;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        r, v, i2v, st, fl;
        logic [15:0] a, b;
        logic        ev1, ev2;
        logic [15:0] ed1, ed2;
        logic        cd1, cd2;
        logic        erdy, eempty, efull;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic v, input logic [15:0] a, input logic [15:0] b,
                                input logic i2v, input logic st, input logic fl,
                                input logic ev1, input logic ev2, input logic [15:0] ed1, input logic [15:0] ed2,
                                input logic cd1, input logic cd2, input logic erdy, input logic eempty,
                                input logic efull);
        vec_t t;
        t.r = r; t.v = v; t.a = a; t.b = b; t.i2v = i2v; t.st = st; t.fl = fl;
        t.ev1 = ev1; t.ev2 = ev2; t.ed1 = ed1; t.ed2 = ed2; t.cd1 = cd1; t.cd2 = cd2;
        t.erdy = erdy; t.eempty = eempty; t.efull = efull;
        return t;
    endfunction

    vec_t tbl[10];

    initial begin
        int k;
        int cyc;
        logic acc;

        //             r  v  a         b         i2v st fl   v1 v2 d1        d2        cd1 cd2 rdy emp full
        tbl[0] = mk(1, 0, 16'h0000, 16'h0000, 0, 0, 0,   0, 0, 16'h0000, 16'h0000, 1, 1, 1, 1, 0);
        tbl[1] = mk(1, 0, 16'h0000, 16'h0000, 0, 0, 0,   0, 0, 16'h0000, 16'h0000, 1, 1, 1, 1, 0);
        tbl[2] = mk(0, 1, 16'h1111, 16'h2222, 1, 0, 0,   0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 0);
        tbl[3] = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 0,   1, 1, 16'h1111, 16'h2222, 1, 1, 1, 1, 0);
        tbl[4] = mk(0, 1, 16'hA00A, 16'h0000, 0, 0, 0,   0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 0);
        tbl[5] = mk(0, 1, 16'hB00B, 16'h0000, 0, 0, 0,   1, 0, 16'hA00A, 16'h0000, 1, 0, 1, 0, 0);
        tbl[6] = mk(0, 1, 16'hC00C, 16'h0000, 0, 0, 0,   1, 0, 16'hB00B, 16'h0000, 1, 0, 1, 0, 0);
        tbl[7] = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 0,   1, 0, 16'hC00C, 16'h0000, 1, 0, 1, 1, 0);
        tbl[8] = mk(0, 0, 16'h0000, 16'hDEAD, 1, 0, 0,   0, 0, 16'h0000, 16'h0000, 0, 0, 1, 1, 0);
        tbl[9] = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 0,   0, 0, 16'h0000, 16'h0000, 0, 0, 1, 1, 0);

        drive(1, 0, '0, '0, 0, 0, 0);
        @(negedge clk);

        // reset, single pair, odd count singles, instr2_vld without imem_vld
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].i2v, tbl[i].st, tbl[i].fl);
            cycle();
            chk1($sformatf("t%0d_vld1", i), bus.ins_new_1_vld, tbl[i].ev1);
            chk1($sformatf("t%0d_vld2", i), bus.ins_new_2_vld, tbl[i].ev2);
            if (tbl[i].cd1) chk16($sformatf("t%0d_instr1", i), bus.new_instr1_in, tbl[i].ed1);
            if (tbl[i].cd2) chk16($sformatf("t%0d_instr2", i), bus.new_instr2_in, tbl[i].ed2);
            chk1($sformatf("t%0d_rdy", i), bus.imem_rdy, tbl[i].erdy);
            chk1($sformatf("t%0d_empty", i), bus.fetch_empty, tbl[i].eempty);
            chk1($sformatf("t%0d_full", i), bus.fetch_full, tbl[i].efull);
        end

        // backpressure: five pairs under stall fill the buffer, then drain 2/cycle
        for (int p = 0; p < 5; p++) begin
            drive(0, 1, 16'h3000 + 16'(2 * p), 16'h3001 + 16'(2 * p), 1, 1, 0);
            cycle();
        end
        drive(0, 0, '0, '0, 0, 1, 0);
        #1;
        chk1("bp_hold_vld1", bus.ins_new_1_vld, 1'b1);
        chk16("bp_hold_instr1", bus.new_instr1_in, 16'h3000);
        chk16("bp_hold_instr2", bus.new_instr2_in, 16'h3001);
        chk1("bp_full", bus.fetch_full, 1'b1);
        chk1("bp_rdy_low", bus.imem_rdy, 1'b0);
        for (int j = 1; j <= 4; j++) begin
            drive(0, 0, '0, '0, 0, 0, 0);
            cycle();
            chk1($sformatf("bp_drain%0d_vld2", j), bus.ins_new_2_vld, 1'b1);
            chk16($sformatf("bp_drain%0d_instr1", j), bus.new_instr1_in, 16'h3000 + 16'(2 * j));
            chk16($sformatf("bp_drain%0d_instr2", j), bus.new_instr2_in, 16'h3001 + 16'(2 * j));
        end
        cycle();
        chk1("bp_done_vld1", bus.ins_new_1_vld, 1'b0);
        chk1("bp_done_empty", bus.fetch_empty, 1'b1);

        // flush with six queued, then two dropped responses, third one issues
        for (int p = 0; p < 4; p++) begin
            drive(0, 1, 16'h5000 + 16'(2 * p), 16'h5001 + 16'(2 * p), 1, 1, 0);
            cycle();
        end
        chk1("fl_pre_vld1", bus.ins_new_1_vld, 1'b1);
        chk1("fl_pre_empty", bus.fetch_empty, 1'b0);
        drive(0, 1, 16'hBAD0, 16'hBAD1, 1, 1, 1);
        cycle();
        chk1("fl_vld1", bus.ins_new_1_vld, 1'b0);
        chk1("fl_vld2", bus.ins_new_2_vld, 1'b0);
        chk1("fl_empty", bus.fetch_empty, 1'b1);
        chk1("fl_rdy_during_flush", bus.imem_rdy, 1'b0);
        drive(0, 1, 16'h6000, 16'h6001, 1, 0, 0);
        #1;
        chk1("fl_drop_rdy", bus.imem_rdy, 1'b1);
        cycle();
        chk1("fl_drop1_empty", bus.fetch_empty, 1'b1);
        drive(0, 1, 16'h6100, 16'h6101, 1, 0, 0);
        cycle();
        chk1("fl_drop2_empty", bus.fetch_empty, 1'b1);
        chk1("fl_drop2_vld1", bus.ins_new_1_vld, 1'b0);
        drive(0, 1, 16'h6200, 16'h6201, 1, 0, 0);
        cycle();
        chk1("fl_r3_empty", bus.fetch_empty, 1'b0);
        chk1("fl_r3_vld1_early", bus.ins_new_1_vld, 1'b0);
        drive(0, 0, '0, '0, 0, 0, 0);
        cycle();
        chk1("fl_r3_vld1", bus.ins_new_1_vld, 1'b1);
        chk16("fl_r3_instr1", bus.new_instr1_in, 16'h6200);
        chk16("fl_r3_instr2", bus.new_instr2_in, 16'h6201);

        // wrap: 20 pairs with random stall, scoreboard checks order and completeness
        drive(1, 0, '0, '0, 0, 0, 0);
        cycle();
        cycle();
        sb_en  = 1'b1;
        issued = 0;
        k      = 0;
        cyc    = 0;
        while (k < 20 && cyc < 600) begin
            drive(0, 1'($urandom_range(0, 3) != 0), 16'h7000 + 16'(2 * k), 16'h7001 + 16'(2 * k),
                  1, 1'($urandom_range(0, 1)), 0);
            acc = bus.imem_vld && model_rdy();
            cycle();
            if (acc) k++;
            cyc++;
        end
        chkint("wrap_pairs_sent", k, 20);
        for (int d = 0; d < 12; d++) begin
            drive(0, 0, '0, '0, 0, 0, 0);
            cycle();
        end
        chkint("wrap_issued", issued, 40);
        chkint("wrap_sb_left", sb_q.size(), 0);
`ifdef FETCH_PERF_EN
        chk16("wrap_perf_flush", perf_flush_cnt, 16'h0000);
`endif
        sb_en = 1'b0;

        // random mix including flush and reset, checked cycle by cycle against the model
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 2) != 0), 16'($urandom),
                  16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 14) == 0));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
